// File: rtl/pong_game_controller.sv
// pong_game_controller: Pong game sequencer. Owns ball position and direction,
// wall bounces, paddle collisions, scoring and the idle/serve/play/point/over
// state machine, and publishes a paddle enable that freezes paddles outside play.
// Build option: define PONG_SPEEDUP_EN to make ball speed start at BALL_SPEED on
// every serve and rise by one per paddle hit, capped at 6. Without it the speed
// is the constant BALL_SPEED.
module pong_game_controller #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PADDLE_W     = 10,
    parameter int unsigned PADDLE_H     = 100,
    parameter int unsigned PADDLE_ONE_X = 20,
    parameter int unsigned PADDLE_TWO_X = 610,
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned SERVE_DELAY  = 60,
    parameter int unsigned WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] paddle_one_y,
    input  logic [9:0] paddle_two_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_one,
    output logic [3:0] score_two,
    output logic       paddles_enable,
    output logic       game_over,
    output logic       winner
);

    localparam int unsigned POS_W   = 10;
    localparam int unsigned ARITH_W = 11;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = $clog2(SERVE_DELAY + 1);

    localparam logic [ARITH_W-1:0] CENTRE_X = ARITH_W'(SCREEN_W / 2 - BALL_SIZE / 2);
    localparam logic [ARITH_W-1:0] CENTRE_Y = ARITH_W'(SCREEN_H / 2 - BALL_SIZE / 2);
    localparam logic [ARITH_W-1:0] X_MAX    = ARITH_W'(SCREEN_W - BALL_SIZE);
    localparam logic [ARITH_W-1:0] Y_MAX    = ARITH_W'(SCREEN_H - BALL_SIZE);
    localparam logic [ARITH_W-1:0] P1_FACE  = ARITH_W'(PADDLE_ONE_X + PADDLE_W);
    localparam logic [ARITH_W-1:0] P2_FACE  = ARITH_W'(PADDLE_TWO_X - BALL_SIZE);
    localparam logic [ARITH_W-1:0] BALL_EXT = ARITH_W'(BALL_SIZE);
    localparam logic [ARITH_W-1:0] PAD_EXT  = ARITH_W'(PADDLE_H);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_END = CNT_W'(SERVE_DELAY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 tick_q;
    logic                 step_c;
    logic [POS_W-1:0]     ball_x_q, ball_x_d;
    logic [POS_W-1:0]     ball_y_q, ball_y_d;
    logic                 dx_q, dx_d;          // 1 = moving right
    logic                 dy_q, dy_d;          // 1 = moving down
    logic                 serve_dx_q, serve_dx_d;
    logic [SCORE_W-1:0]   score_one_q, score_one_d;
    logic [SCORE_W-1:0]   score_two_q, score_two_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_inc_c;
    logic                 winner_q, winner_d;
    logic                 paddles_enable_q, paddles_enable_d;
    logic                 game_over_q, game_over_d;

    logic [ARITH_W-1:0]   spd_c;
    logic [ARITH_W-1:0]   bx_c, by_c, p1y_c, p2y_c;
    logic [ARITH_W-1:0]   nx_c, ny_c;
    logic                 ndx_c, ndy_c;
    logic                 ov1_c, ov2_c;
    logic                 miss_c;
    logic                 win_c;

    // Frame tick edge detector: one-clk step pulse per tick rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_q <= 1'b0;
        else        tick_q <= tick;
    end

    assign step_c    = tick & ~tick_q;
    assign cnt_inc_c = cnt_q + CNT_W'(1);

`ifdef PONG_SPEEDUP_EN
    localparam int unsigned        SPEED_W   = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(6);

    logic [SPEED_W-1:0] speed_q, speed_d;

    // Speed reloads on every serve entry and climbs by one per paddle hit
    always_comb begin
        speed_d = speed_q;
        if (state_d == S_SERVE && state_q != S_SERVE) begin
            speed_d = SPEED_W'(BALL_SPEED);
        end else if (state_q == S_PLAY && step_c && !miss_c && ndx_c != dx_q
                     && speed_q < SPEED_MAX) begin
            speed_d = speed_q + SPEED_W'(1);
        end
    end

    // Speed register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) speed_q <= SPEED_W'(BALL_SPEED);
        else        speed_q <= speed_d;
    end

    assign spd_c = ARITH_W'(speed_q);
`else
    assign spd_c = ARITH_W'(BALL_SPEED);
`endif

    // Candidate ball motion for one play step, horizontal and vertical independent
    always_comb begin
        bx_c   = {1'b0, ball_x_q};
        by_c   = {1'b0, ball_y_q};
        p1y_c  = {1'b0, paddle_one_y};
        p2y_c  = {1'b0, paddle_two_y};
        ov1_c  = (by_c + BALL_EXT > p1y_c) && (by_c < p1y_c + PAD_EXT);
        ov2_c  = (by_c + BALL_EXT > p2y_c) && (by_c < p2y_c + PAD_EXT);
        nx_c   = bx_c;
        ndx_c  = dx_q;
        miss_c = 1'b0;
        ny_c   = by_c;
        ndy_c  = dy_q;

        if (!dx_q) begin
            if (bx_c >= P1_FACE && bx_c - spd_c <= P1_FACE && ov1_c) begin
                nx_c  = P1_FACE;
                ndx_c = 1'b1;
            end else if (bx_c <= spd_c) begin
                miss_c = 1'b1;
            end else begin
                nx_c = bx_c - spd_c;
            end
        end else begin
            if (bx_c <= P2_FACE && bx_c + spd_c >= P2_FACE && ov2_c) begin
                nx_c  = P2_FACE;
                ndx_c = 1'b0;
            end else if (bx_c + spd_c >= X_MAX) begin
                miss_c = 1'b1;
            end else begin
                nx_c = bx_c + spd_c;
            end
        end

        if (dy_q) begin
            if (by_c + spd_c >= Y_MAX) begin
                ny_c  = Y_MAX;
                ndy_c = 1'b0;
            end else begin
                ny_c = by_c + spd_c;
            end
        end else begin
            if (by_c <= spd_c) begin
                ny_c  = '0;
                ndy_c = 1'b1;
            end else begin
                ny_c = by_c - spd_c;
            end
        end
    end

    // The scorer of the last point is the player the next serve moves away from
    assign win_c = serve_dx_q ? (score_one_q == WIN) : (score_two_q == WIN);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start only matters in IDLE and OVER, where it beats a step
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SERVE;
            S_SERVE: if (step_c && cnt_inc_c == SERVE_END) state_d = S_PLAY;
            S_PLAY:  if (step_c && miss_c) state_d = S_POINT;
            S_POINT: if (step_c) state_d = win_c ? S_OVER : S_SERVE;
            S_OVER:  if (start) state_d = S_SERVE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered status outputs follow the state being entered
    always_comb begin
        paddles_enable_d = (state_d == S_SERVE) || (state_d == S_PLAY);
        game_over_d      = (state_d == S_OVER);
    end

    // Ball, score, counter and winner updates per state
    always_comb begin
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        serve_dx_d  = serve_dx_q;
        score_one_d = score_one_q;
        score_two_d = score_two_q;
        cnt_d       = cnt_q;
        winner_d    = winner_q;

        case (state_q)
            S_IDLE: begin
                ball_x_d = POS_W'(CENTRE_X);
                ball_y_d = POS_W'(CENTRE_Y);
                if (start) cnt_d = '0;
            end
            S_SERVE: begin
                ball_x_d = POS_W'(CENTRE_X);
                ball_y_d = POS_W'(CENTRE_Y);
                if (step_c) cnt_d = cnt_inc_c;
            end
            S_PLAY: begin
                if (step_c) begin
                    ball_y_d = POS_W'(ny_c);
                    dy_d     = ndy_c;
                    if (miss_c) begin
                        serve_dx_d = dx_q;
                        if (!dx_q) begin
                            if (score_two_q < WIN) score_two_d = score_two_q + SCORE_W'(1);
                        end else begin
                            if (score_one_q < WIN) score_one_d = score_one_q + SCORE_W'(1);
                        end
                    end else begin
                        ball_x_d = POS_W'(nx_c);
                        dx_d     = ndx_c;
                    end
                end
            end
            S_POINT: begin
                if (step_c) begin
                    if (win_c) begin
                        winner_d = ~serve_dx_q;
                    end else begin
                        cnt_d    = '0;
                        ball_x_d = POS_W'(CENTRE_X);
                        ball_y_d = POS_W'(CENTRE_Y);
                        dx_d     = serve_dx_q;
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    score_one_d = '0;
                    score_two_d = '0;
                    cnt_d       = '0;
                    ball_x_d    = POS_W'(CENTRE_X);
                    ball_y_d    = POS_W'(CENTRE_Y);
                    dx_d        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ball_x_q         <= POS_W'(CENTRE_X);
            ball_y_q         <= POS_W'(CENTRE_Y);
            dx_q             <= 1'b1;
            dy_q             <= 1'b1;
            serve_dx_q       <= 1'b1;
            score_one_q      <= '0;
            score_two_q      <= '0;
            cnt_q            <= '0;
            winner_q         <= 1'b0;
            paddles_enable_q <= 1'b0;
            game_over_q      <= 1'b0;
        end else begin
            ball_x_q         <= ball_x_d;
            ball_y_q         <= ball_y_d;
            dx_q             <= dx_d;
            dy_q             <= dy_d;
            serve_dx_q       <= serve_dx_d;
            score_one_q      <= score_one_d;
            score_two_q      <= score_two_d;
            cnt_q            <= cnt_d;
            winner_q         <= winner_d;
            paddles_enable_q <= paddles_enable_d;
            game_over_q      <= game_over_d;
        end
    end

    assign ball_x         = ball_x_q;
    assign ball_y         = ball_y_q;
    assign score_one      = score_one_q;
    assign score_two      = score_two_q;
    assign paddles_enable = paddles_enable_q;
    assign game_over      = game_over_q;
    assign winner         = winner_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// tb_pong_game_controller: directed bench for the Pong game sequencer.
// Ball trajectory checkpoints below are derived by hand from the serve at
// (316,236) moving right/down at 2 pixels per step.
module tb_pong_game_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic [9:0] paddle_one_y;
    logic [9:0] paddle_two_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_one;
    logic [3:0] score_two;
    logic       paddles_enable;
    logic       game_over;
    logic       winner;

    logic       p1_auto;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    pong_game_controller dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .start          (start),
        .paddle_one_y   (paddle_one_y),
        .paddle_two_y   (paddle_two_y),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .score_one      (score_one),
        .score_two      (score_two),
        .paddles_enable (paddles_enable),
        .game_over      (game_over),
        .winner         (winner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One game step: paddle two tracks the ball, paddle one optionally dodges it
    task automatic step();
        @(negedge clk);
        if (p1_auto) paddle_one_y = (ball_y >= 10'd240) ? 10'd0 : 10'd380;
        paddle_two_y = (ball_y >= 10'd40) ? (ball_y - 10'd40) : 10'd0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        tick         = 1'b0;
        start        = 1'b0;
        paddle_one_y = 10'd100;
        paddle_two_y = 10'd0;
        p1_auto      = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_ball_x", 32'(ball_x), 32'd316);
        chk("rst_ball_y", 32'(ball_y), 32'd236);
        chk("rst_score_one", 32'(score_one), 32'd0);
        chk("rst_score_two", 32'(score_two), 32'd0);
        chk("rst_paddles_en", 32'(paddles_enable), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        reset = 1'b1;

        // IDLE ignores steps
        step();
        chk("idle_step_x", 32'(ball_x), 32'd316);
        chk("idle_paddles_en", 32'(paddles_enable), 32'd0);

        // Start and step together in IDLE: start wins, step adds nothing to the serve count
        @(negedge clk);
        start = 1'b1;
        tick  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick  = 1'b0;
        chk("serve_paddles_en", 32'(paddles_enable), 32'd1);
        step_n(59);
        chk("serve59_x", 32'(ball_x), 32'd316);
        step();
        chk("serve60_x", 32'(ball_x), 32'd316);
        chk("serve60_y", 32'(ball_y), 32'd236);
        step();
        chk("play1_x", 32'(ball_x), 32'd318);
        chk("play1_y", 32'(ball_y), 32'd238);

        // start is ignored during play
        pulse_start();
        chk("play_start_ign_x", 32'(ball_x), 32'd318);
        chk("play_start_ign_en", 32'(paddles_enable), 32'd1);

        // Bottom wall bounce: y 470 -> 472 -> 470
        step_n(116);
        chk("k117_x", 32'(ball_x), 32'd550);
        chk("k117_y", 32'(ball_y), 32'd470);
        step();
        chk("k118_y", 32'(ball_y), 32'd472);
        chk("k118_x", 32'(ball_x), 32'd552);
        step();
        chk("k119_y", 32'(ball_y), 32'd470);

        // Paddle two hit at its face column 602
        step_n(23);
        chk("k142_x", 32'(ball_x), 32'd600);
        chk("k142_y", 32'(ball_y), 32'd424);
        step();
        chk("k143_x", 32'(ball_x), 32'd602);
        chk("k143_y", 32'(ball_y), 32'd422);
        step();
        chk("k144_x", 32'(ball_x), 32'd600);

        // Top wall bounce clamps to 0
        step_n(210);
        chk("k354_y", 32'(ball_y), 32'd0);
        chk("k354_x", 32'(ball_x), 32'd180);

        // Paddle one hit: ball at (32,148) moving left, paddle_one_y=100
        step_n(74);
        chk("k428_x", 32'(ball_x), 32'd32);
        chk("k428_y", 32'(ball_y), 32'd148);
        step();
        chk("p1_hit_x", 32'(ball_x), 32'd30);
        chk("p1_hit_y", 32'(ball_y), 32'd150);
        chk("p1_hit_score_two", 32'(score_two), 32'd0);
        step();
        chk("p1_hit_dx_right", 32'(ball_x), 32'd32);

        // Player one now dodges every ball: first miss
        p1_auto = 1'b1;
        for (int i = 0; i < 4000 && score_two == 4'd0; i++) step();
        chk("miss1_score_two", 32'(score_two), 32'd1);
        chk("miss1_score_one", 32'(score_one), 32'd0);
        chk("miss1_paddles_en", 32'(paddles_enable), 32'd0);
        chk("miss1_frozen_x", 32'(ball_x), 32'd2);
        chk("miss1_game_over", 32'(game_over), 32'd0);
        step();
        chk("reserve_x", 32'(ball_x), 32'd316);
        chk("reserve_y", 32'(ball_y), 32'd236);
        chk("reserve_paddles_en", 32'(paddles_enable), 32'd1);
        step_n(60);
        chk("reserve60_x", 32'(ball_x), 32'd316);
        step();
        chk("reserve_dx_left", 32'(ball_x), 32'd314);

        // Remaining misses until player two wins
        for (int i = 0; i < 8000 && game_over == 1'b0; i++) step();
        chk("over_game_over", 32'(game_over), 32'd1);
        chk("over_score_two", 32'(score_two), 32'd7);
        chk("over_score_one", 32'(score_one), 32'd0);
        chk("over_winner", 32'(winner), 32'd1);
        chk("over_paddles_en", 32'(paddles_enable), 32'd0);
        step();
        chk("over_step_hold", 32'(game_over), 32'd1);
        chk("over_step_score", 32'(score_two), 32'd7);

        // Restart from OVER
        pulse_start();
        chk("restart_score_two", 32'(score_two), 32'd0);
        chk("restart_score_one", 32'(score_one), 32'd0);
        chk("restart_game_over", 32'(game_over), 32'd0);
        chk("restart_paddles_en", 32'(paddles_enable), 32'd1);
        chk("restart_x", 32'(ball_x), 32'd316);
        chk("restart_y", 32'(ball_y), 32'd236);
        step_n(63);
        chk("restart_play3_x", 32'(ball_x), 32'd322);

        // Asynchronous reset in the middle of play
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_x", 32'(ball_x), 32'd316);
        chk("midrst_paddles_en", 32'(paddles_enable), 32'd0);
        @(negedge clk);
        chk("midrst_y", 32'(ball_y), 32'd236);
        chk("midrst_game_over", 32'(game_over), 32'd0);
        chk("midrst_score_two", 32'(score_two), 32'd0);
        reset = 1'b1;
        step();
        chk("midrst_idle_x", 32'(ball_x), 32'd316);
        chk("midrst_idle_en", 32'(paddles_enable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
